// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
// Optional build macro: SYNC_FIFO_FWFT_EN (first-word fall-through read port).
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Occupancy type for the default configuration (0..DEPTH needs one extra bit).
  typedef logic [$clog2(DEFAULT_DEPTH):0] count_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_ram_dp.sv
// DEPTH x DATA_WIDTH dual-port storage for sync_fifo_param.
// Synchronous write port; read port is registered by default and becomes a
// plain combinational read when SYNC_FIFO_FWFT_EN is defined.
module fifo_ram_dp
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: storage carries no reset, contents survive flush.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Fall-through: head word is visible without a clock edge.
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rd_en ^ rst_an;
  assign rd_data        = mem_q[rd_addr];
`else
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // Read stage: capture head word on an accepted pop, hold otherwise.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      rd_data_p1 <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_p1;
`endif

endmodule : fifo_ram_dp

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, and synchronous flush.
// Optional build macro: SYNC_FIFO_FWFT_EN (first-word fall-through mode).
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Occupancy update with clamping at both ends; simultaneous push/pop cancel.
  function automatic logic [ADDR_WIDTH:0] next_count(
    input logic [ADDR_WIDTH:0] cur,
    input logic                push,
    input logic                pop
  );
    logic [ADDR_WIDTH:0] nxt;
    nxt = cur;
    if (push && !pop && (cur != DEPTH_C)) begin
      nxt = cur + 1'b1;
    end else if (pop && !push && (cur != '0)) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  // Flags decode from the registered count only.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses registered flags; flush blocks both ports.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = next_count(count_q, wr_acc, rd_acc);
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_an  (rst_an),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown whenever the FIFO holds data; zero otherwise.
  assign rd_valid = !empty;
  assign rd_data  = rd_valid ? ram_rd_data : '0;
`else
  logic vld_p1;

  // Read stage valid: travels with the registered RAM output.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
    end
  end

  assign rd_valid = vld_p1;
  assign rd_data  = ram_rd_data;
`endif

endmodule : sync_fifo_param
